// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the rv32 memory-access stage: access widths,
// branch op codes and the bus FSM state type.
package rv32_mem_pkg;

    localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'b01;
    localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'b10;

    // Must stay in step with the encodings used by rv32_branch.
    localparam logic [1:0] RV32_BRANCH_OP_NEVER    = 2'b00;
    localparam logic [1:0] RV32_BRANCH_OP_ZERO     = 2'b01;
    localparam logic [1:0] RV32_BRANCH_OP_NON_ZERO = 2'b10;
    localparam logic [1:0] RV32_BRANCH_OP_ALWAYS   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    function automatic logic branch_taken(input logic [1:0] op, input logic non_zero);
        return (op == RV32_BRANCH_OP_ALWAYS)
            || (op == RV32_BRANCH_OP_ZERO && !non_zero)
            || (op == RV32_BRANCH_OP_NON_ZERO && non_zero);
    endfunction

endpackage

// File: rtl/rv32_mem_align.sv
// Combinational byte-lane steering: store mask/data replication and
// load extraction with sign or zero extension.
module rv32_mem_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_offset,
    input  logic        i_zero_extend,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_buf,
    output logic [3:0]  o_write_mask,
    output logic [31:0] o_write_value,
    output logic [31:0] o_load_value
);

    logic [31:0] w_shifted;

    assign w_shifted = i_load_buf >> {i_offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_write_mask  = 4'b1111;
        o_write_value = i_store_data;
        o_load_value  = w_shifted;
        case (i_width)
            RV32_MEM_WIDTH_BYTE: begin
                o_write_mask  = 4'b0001 << i_offset;
                o_write_value = {4{i_store_data[7:0]}};
                o_load_value  = i_zero_extend ? {24'h0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            RV32_MEM_WIDTH_HALF: begin
                o_write_mask  = 4'b0011 << i_offset;
                o_write_value = {2{i_store_data[15:0]}};
                o_load_value  = i_zero_extend ? {16'h0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32_mem.sv
// rv32 memory-access stage: registered data-bus loads/stores with a
// three-state stall FSM, branch resolution and the writeback register.
module rv32_mem
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        valid_in,
    input  logic        branch_predicted_taken_in,
    input  logic        alu_non_zero_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_zero_extend_in,
    input  logic        mem_fence_in,
    input  logic [1:0]  mem_width_in,
    input  logic [1:0]  branch_op_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        stall_out,
    output logic        branch_mispredicted_out,
    output logic [31:0] branch_pc_out,
    output logic        fence_out,
    output logic        valid_out,
    output logic        rd_write_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rd_value_out
);

    mem_state_e  r_state;
    mem_state_e  w_state_next;
    logic [31:0] r_address, r_write_value, r_load_buf, r_rd_value;
    logic        r_read, r_write, r_flushed, r_valid, r_rd_write;
    logic [3:0]  r_mask;
    logic [4:0]  r_rd;
    logic        w_access, w_advance, w_kill;
    logic [3:0]  w_write_mask;
    logic [31:0] w_write_value, w_load_value;

    rv32_mem_align u_align (
        .i_width       (mem_width_in),
        .i_offset      (result_in[1:0]),
        .i_zero_extend (mem_zero_extend_in),
        .i_store_data  (rs2_value_in),
        .i_load_buf    (r_load_buf),
        .o_write_mask  (w_write_mask),
        .o_write_value (w_write_value),
        .o_load_value  (w_load_value)
    );

    assign w_access  = valid_in && (mem_read_in || mem_write_in) && !flush_in;
    assign stall_out = (r_state == ST_IDLE && w_access) || r_state == ST_BUSY;
    assign w_advance = !stall_in && !stall_out;
    // A flush seen mid-access is remembered so the result is dropped on advance.
    assign w_kill    = flush_in || r_flushed;

    assign branch_mispredicted_out = valid_in && !flush_in
        && (branch_taken(branch_op_in, alu_non_zero_in) != branch_predicted_taken_in);
    assign branch_pc_out = branch_pc_in;
    assign fence_out     = valid_in && mem_fence_in && !flush_in;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_access)      w_state_next = ST_BUSY;
            ST_BUSY: if (data_ready_in) w_state_next = ST_DONE;
            ST_DONE: if (!stall_in)     w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_address     <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_mask        <= '0;
            r_write_value <= '0;
        end else if (r_state == ST_IDLE && w_access) begin
            r_address     <= {result_in[31:2], 2'b00};
            r_read        <= mem_read_in;
            r_write       <= mem_write_in;
            r_mask        <= w_write_mask;
            r_write_value <= w_write_value;
        end else if (r_state == ST_BUSY && data_ready_in) begin
            r_read        <= 1'b0;
            r_write       <= 1'b0;
        end
    end

    // NOTE: the load buffer is pure datapath, always written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_BUSY && data_ready_in) r_load_buf <= data_read_value_in;
    end

    always_ff @(posedge clk) begin
        if (reset || w_advance)                       r_flushed <= 1'b0;
        else if (r_state != ST_IDLE && flush_in)      r_flushed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_rd       <= '0;
            r_rd_write <= 1'b0;
            r_rd_value <= '0;
        end else if (w_advance) begin
            r_valid    <= valid_in && !w_kill;
            r_rd       <= rd_in;
            r_rd_write <= rd_write_in && !w_kill;
            r_rd_value <= mem_read_in ? w_load_value : result_in;
        end
    end

    assign data_address_out     = r_address;
    assign data_read_out        = r_read;
    assign data_write_out       = r_write;
    assign data_write_mask_out  = r_mask;
    assign data_write_value_out = r_write_value;
    assign valid_out            = r_valid;
    assign rd_out               = r_rd;
    assign rd_write_out         = r_rd_write;
    assign rd_value_out         = r_rd_value;

endmodule

// File: tb/tb_rv32_mem.sv
// Scoreboard bench for rv32_mem: expected bus requests and writeback
// results are queued at issue and compared as the stage produces them.
module tb_rv32_mem;
    import rv32_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in, valid_in, branch_predicted_taken_in;
    logic        alu_non_zero_in, mem_read_in, mem_write_in, mem_zero_extend_in, mem_fence_in;
    logic [1:0]  mem_width_in, branch_op_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic [31:0] result_in, rs2_value_in, branch_pc_in;
    logic [31:0] data_address_out, data_write_value_out, data_read_value_in;
    logic        data_read_out, data_write_out, data_ready_in;
    logic [3:0]  data_write_mask_out;
    logic        stall_out, branch_mispredicted_out, fence_out, valid_out, rd_write_out;
    logic [31:0] branch_pc_out, rd_value_out;
    logic [4:0]  rd_out;

    rv32_mem dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .branch_predicted_taken_in(branch_predicted_taken_in),
        .alu_non_zero_in(alu_non_zero_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_zero_extend_in(mem_zero_extend_in),
        .mem_fence_in(mem_fence_in), .mem_width_in(mem_width_in),
        .branch_op_in(branch_op_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
        .result_in(result_in), .rs2_value_in(rs2_value_in), .branch_pc_in(branch_pc_in),
        .data_address_out(data_address_out), .data_read_out(data_read_out),
        .data_write_out(data_write_out), .data_write_mask_out(data_write_mask_out),
        .data_write_value_out(data_write_value_out), .data_read_value_in(data_read_value_in),
        .data_ready_in(data_ready_in), .stall_out(stall_out),
        .branch_mispredicted_out(branch_mispredicted_out), .branch_pc_out(branch_pc_out),
        .fence_out(fence_out), .valid_out(valid_out), .rd_write_out(rd_write_out),
        .rd_out(rd_out), .rd_value_out(rd_value_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_read, mem_write, zext, fence, pred_taken, non_zero, rd_write, flush_busy;
        logic [1:0]  width, bop;
        logic [4:0]  rd;
        logic [31:0] result, rs2, bpc, rdata;
        int          waits, hold;
    } instr_t;

    typedef struct {
        logic        valid, rd_write;
        logic [4:0]  rd;
        logic [31:0] value;
    } wb_t;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wval;
        logic [3:0]  mask;
    } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_taken(input logic [1:0] op, input logic nz);
        case (op)
            RV32_BRANCH_OP_ALWAYS:   return 1'b1;
            RV32_BRANCH_OP_ZERO:     return !nz;
            RV32_BRANCH_OP_NON_ZERO: return nz;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input instr_t ins);
        logic [7:0]  b [4];
        logic [15:0] h;
        int          off = int'(ins.result[1:0]);
        for (int i = 0; i < 4; i++) b[i] = ins.rdata[8*i +: 8];
        if (ins.width == RV32_MEM_WIDTH_BYTE)
            return ins.zext ? {24'h0, b[off]} : {{24{b[off][7]}}, b[off]};
        if (ins.width == RV32_MEM_WIDTH_HALF) begin
            h = {b[off+1], b[off]};
            return ins.zext ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return ins.rdata;
    endfunction

    function automatic bus_t model_bus(input instr_t ins);
        bus_t e;
        int   off = int'(ins.result[1:0]);
        e.rd   = ins.mem_read;
        e.wr   = ins.mem_write;
        e.addr = {ins.result[31:2], 2'b00};
        for (int i = 0; i < 4; i++)
            e.mask[i] = (ins.width == RV32_MEM_WIDTH_WORD) || (i == off)
                     || (ins.width == RV32_MEM_WIDTH_HALF && i == off + 1);
        e.wval = (ins.width == RV32_MEM_WIDTH_BYTE) ? {4{ins.rs2[7:0]}} :
                 (ins.width == RV32_MEM_WIDTH_HALF) ? {2{ins.rs2[15:0]}} : ins.rs2;
        return e;
    endfunction

    function automatic instr_t blank();
        instr_t ins;
        ins = '{mem_read: 0, mem_write: 0, zext: 0, fence: 0, pred_taken: 0, non_zero: 0,
                rd_write: 0, flush_busy: 0, width: RV32_MEM_WIDTH_WORD, bop: RV32_BRANCH_OP_NEVER,
                rd: 0, result: 0, rs2: 0, bpc: 0, rdata: 0, waits: 0, hold: 0};
        return ins;
    endfunction

    // Entered just after a rising edge; returns just after the edge on which the stage advances.
    task automatic run_instr(input string name, input instr_t ins);
        wb_t  ew, gw;
        bus_t eb, gb;
        int   stalls = 0, strobes = 0, hold_left = ins.hold;
        logic is_mem = ins.mem_read || ins.mem_write;
        logic done = 1'b0;
        valid_in = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        mem_read_in = ins.mem_read; mem_write_in = ins.mem_write; mem_zero_extend_in = ins.zext;
        mem_fence_in = ins.fence; mem_width_in = ins.width; branch_op_in = ins.bop;
        branch_predicted_taken_in = ins.pred_taken; alu_non_zero_in = ins.non_zero;
        rd_in = ins.rd; rd_write_in = ins.rd_write; result_in = ins.result;
        rs2_value_in = ins.rs2; branch_pc_in = ins.bpc;
        wb_q.push_back('{valid: !ins.flush_busy, rd_write: ins.rd_write && !ins.flush_busy,
                         rd: ins.rd, value: ins.mem_read ? model_load(ins) : ins.result});
        if (is_mem) bus_q.push_back(model_bus(ins));
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check({name, ".mispredict"}, 32'(branch_mispredicted_out),
                      32'(model_taken(ins.bop, ins.non_zero) != ins.pred_taken));
                check({name, ".branch_pc"}, branch_pc_out, ins.bpc);
                check({name, ".fence"}, 32'(fence_out), 32'(ins.fence));
            end
            if (stall_out) stalls++;
            if (data_read_out || data_write_out) begin
                strobes++;
                if (strobes == 1 && bus_q.size() > 0) begin
                    eb = bus_q.pop_front();
                    gb = '{rd: data_read_out, wr: data_write_out, addr: data_address_out,
                           wval: data_write_value_out, mask: data_write_mask_out};
                    check({name, ".bus_read"},  32'(gb.rd),   32'(eb.rd));
                    check({name, ".bus_write"}, 32'(gb.wr),   32'(eb.wr));
                    check({name, ".bus_addr"},  gb.addr,      eb.addr);
                    check({name, ".bus_mask"},  32'(gb.mask), 32'(eb.mask));
                    if (eb.wr) check({name, ".bus_wval"}, gb.wval, eb.wval);
                end
                data_ready_in      = (strobes == ins.waits + 1);
                data_read_value_in = data_ready_in ? ins.rdata : $urandom;
                flush_in           = ins.flush_busy && strobes == 1;
                stall_in           = 1'b0;
            end else begin
                // Ready held high outside an access must be ignored.
                data_ready_in      = 1'b1;
                data_read_value_in = $urandom;
                flush_in           = 1'b0;
                stall_in           = (strobes > 0 && hold_left > 0);
                if (stall_in) hold_left--;
            end
            done = !stall_out && !stall_in;
        end
        if (!done) check({name, ".timeout"}, 32'd1, 32'd0);
        @(posedge clk); #1;
        flush_in = 1'b0; stall_in = 1'b0;
        check({name, ".stall_cycles"},  32'(stalls),  is_mem ? 32'(ins.waits + 2) : 32'd0);
        check({name, ".strobe_cycles"}, 32'(strobes), is_mem ? 32'(ins.waits + 1) : 32'd0);
        ew = wb_q.pop_front();
        gw = '{valid: valid_out, rd_write: rd_write_out, rd: rd_out, value: rd_value_out};
        check({name, ".valid_out"},    32'(gw.valid),    32'(ew.valid));
        check({name, ".rd_write_out"}, 32'(gw.rd_write), 32'(ew.rd_write));
        check({name, ".rd_out"},       32'(gw.rd),       32'(ew.rd));
        check({name, ".rd_value_out"}, gw.value,         ew.value);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ".addr"},    data_address_out,            32'h0);
        check({name, ".strobes"}, {30'h0, data_read_out, data_write_out}, 32'h0);
        check({name, ".mask"},    32'(data_write_mask_out),    32'h0);
        check({name, ".wval"},    data_write_value_out,        32'h0);
        check({name, ".wb"},      {26'h0, valid_out, rd_write_out, 4'h0}, 32'h0);
        check({name, ".rd_out"},  32'(rd_out),                 32'h0);
        check({name, ".rd_value"}, rd_value_out,               32'h0);
    endtask

    instr_t ins;

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
        branch_predicted_taken_in = 1'b0; alu_non_zero_in = 1'b0; mem_read_in = 1'b0;
        mem_write_in = 1'b0; mem_zero_extend_in = 1'b0; mem_fence_in = 1'b0;
        mem_width_in = 2'b00; branch_op_in = 2'b00; rd_in = '0; rd_write_in = 1'b0;
        result_in = '0; rs2_value_in = '0; branch_pc_in = '0;
        data_read_value_in = '0; data_ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset.stall_out", 32'(stall_out), 32'h0);
        reset = 1'b0;

        ins = blank(); ins.result = 32'h1234; ins.rd = 5; ins.rd_write = 1;
        run_instr("alu", ins);

        ins = blank(); ins.mem_read = 1; ins.width = RV32_MEM_WIDTH_BYTE; ins.result = 32'h103;
        ins.rdata = 32'h80FF_FFFF; ins.rd = 7; ins.rd_write = 1;
        run_instr("lb", ins);

        ins = blank(); ins.mem_write = 1; ins.width = RV32_MEM_WIDTH_HALF; ins.result = 32'h202;
        ins.rs2 = 32'hABCD_1234; ins.waits = 3;
        run_instr("sh", ins);

        ins = blank(); ins.bop = RV32_BRANCH_OP_ZERO; ins.bpc = 32'h400;
        run_instr("beq_nt", ins);
        ins.pred_taken = 1;
        run_instr("beq_pt", ins);
        ins = blank(); ins.bop = RV32_BRANCH_OP_NON_ZERO; ins.non_zero = 1; ins.bpc = 32'h880;
        run_instr("bne", ins);
        ins = blank(); ins.bop = RV32_BRANCH_OP_ALWAYS; ins.pred_taken = 1; ins.bpc = 32'hC0;
        run_instr("jal", ins);
        ins = blank(); ins.fence = 1; ins.result = 32'h55;
        run_instr("fence", ins);

        ins = blank(); ins.mem_write = 1; ins.width = RV32_MEM_WIDTH_WORD; ins.result = 32'h300;
        ins.rs2 = 32'hCAFE_F00D; ins.rd = 3; ins.rd_write = 1; ins.waits = 1; ins.flush_busy = 1;
        run_instr("flush_sw", ins);

        ins = blank(); ins.mem_read = 1; ins.width = RV32_MEM_WIDTH_HALF; ins.result = 32'h42;
        ins.zext = 1; ins.rdata = 32'h9876_5432; ins.rd = 9; ins.rd_write = 1; ins.hold = 2;
        run_instr("lhu_hold", ins);

        for (int k = 0; k < 10; k++) begin
            logic [31:0] r = $urandom;
            ins = blank();
            ins.mem_read  = r[0];
            ins.mem_write = !r[0];
            ins.zext      = r[1];
            ins.width     = (r[3:2] == 2'b11) ? RV32_MEM_WIDTH_WORD : r[3:2];
            ins.result    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} >> 0;
            ins.result[1:0] = (ins.width == RV32_MEM_WIDTH_BYTE) ? r[5:4] :
                              (ins.width == RV32_MEM_WIDTH_HALF) ? {r[4], 1'b0} : 2'b00;
            ins.rs2       = $urandom;
            ins.rdata     = $urandom;
            ins.rd        = r[10:6];
            ins.rd_write  = 1;
            ins.waits     = int'(r[12:11]);
            run_instr($sformatf("rand%0d", k), ins);
        end

        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; result_in = 32'h500;
        data_ready_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy.pre_strobe", 32'(data_read_out), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check_outputs_zero("rst_busy");
        reset = 1'b0;
        #1;
        check("rst_busy.stall_out", 32'(stall_out), 32'h0);
        @(posedge clk); #1;
        check("rst_busy.idle_strobes", {30'h0, data_read_out, data_write_out}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
